// File: rtl/cnn_pkg.sv
// Shared constants, the window_fetch state type and the window flattening
// helper used by the CNN datapath blocks.
package cnn_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int ADDR_WIDTH  = 16;
  localparam int KERNEL_SIZE = 5;
  localparam int DIM_WIDTH   = 8;

  typedef enum logic [2:0] {
    WF_IDLE,
    WF_FETCH,
    WF_DRAIN,
    WF_HOLD,
    WF_DONE
  } wf_state_e;

  // Bit offset of tap (r,c) inside a flattened k x k window of dw-bit words.
  function automatic int tap_lsb(input int r, input int c, input int k, input int dw);
    return (r * k + c) * dw;
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Walks the K x K taps of one window in row-major order, producing the tap
// address with adds only and flagging taps that fall outside the map.
module window_addr_gen
  import cnn_pkg::*;
#(
  parameter int ADDR_WIDTH = cnn_pkg::ADDR_WIDTH,
  parameter int DIM_WIDTH  = cnn_pkg::DIM_WIDTH,
  parameter int K          = cnn_pkg::KERNEL_SIZE,
  parameter int CW         = DIM_WIDTH + 3,
  parameter int TW         = $clog2(K * K)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [ADDR_WIDTH-1:0] i_win_addr,
  input  logic signed [CW-1:0]  i_py,
  input  logic signed [CW-1:0]  i_px,
  input  logic [DIM_WIDTH-1:0]  i_img_w,
  input  logic [DIM_WIDTH-1:0]  i_img_h,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_in_bounds,
  output logic [TW-1:0]         o_tap,
  output logic                  o_last
);

  localparam int RW = $clog2(K);
  localparam logic [RW-1:0]        COL_LAST = RW'(K - 1);
  localparam logic [TW-1:0]        TAP_LAST = TW'(K * K - 1);
  localparam logic signed [CW-1:0] ONE_S    = CW'(1);
  localparam logic signed [CW-1:0] ZERO_S   = CW'(0);

  logic [RW-1:0]         r_col;
  logic [TW-1:0]         r_tap;
  logic [ADDR_WIDTH-1:0] r_row_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic signed [CW-1:0]  r_y;
  logic signed [CW-1:0]  r_x;
  logic signed [CW-1:0]  r_x0;

  logic [ADDR_WIDTH-1:0] w_img_w_a;
  logic signed [CW-1:0]  w_img_w_s;
  logic signed [CW-1:0]  w_img_h_s;

  assign w_img_w_a = ADDR_WIDTH'(i_img_w);
  assign w_img_w_s = CW'(i_img_w);
  assign w_img_h_s = CW'(i_img_h);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= '0;
      r_tap      <= '0;
      r_row_addr <= '0;
      r_addr     <= '0;
      r_y        <= '0;
      r_x        <= '0;
      r_x0       <= '0;
    end else if (i_load) begin
      r_col      <= '0;
      r_tap      <= '0;
      r_row_addr <= i_win_addr;
      r_addr     <= i_win_addr;
      r_y        <= i_py;
      r_x        <= i_px;
      r_x0       <= i_px;
    end else if (i_step) begin
      r_tap <= r_tap + TW'(1);
      if (r_col == COL_LAST) begin
        // Row wrap: next row start is one image width below the current one.
        r_col      <= '0;
        r_row_addr <= r_row_addr + w_img_w_a;
        r_addr     <= r_row_addr + w_img_w_a;
        r_y        <= r_y + ONE_S;
        r_x        <= r_x0;
      end else begin
        r_col  <= r_col + RW'(1);
        r_addr <= r_addr + ADDR_WIDTH'(1);
        r_x    <= r_x + ONE_S;
      end
    end
  end

  assign o_addr      = r_addr;
  assign o_tap       = r_tap;
  assign o_last      = (r_tap == TAP_LAST);
  assign o_in_bounds = (r_y >= ZERO_S) && (r_y < w_img_h_s) &&
                       (r_x >= ZERO_S) && (r_x < w_img_w_s);

endmodule

// File: rtl/window_fetch.sv
// Walks a 2-D feature map and presents each KxK window as a flat tap vector.
// Optional zero padding of (K-1)/2 on every side: WINDOW_FETCH_ZERO_PAD_EN.
module window_fetch
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cnn_pkg::ADDR_WIDTH,
  parameter int K          = cnn_pkg::KERNEL_SIZE,
  parameter int DIM_WIDTH  = cnn_pkg::DIM_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [DIM_WIDTH-1:0]        img_w,
  input  logic [DIM_WIDTH-1:0]        img_h,
  input  logic [1:0]                  stride,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_en,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [K*K*DATA_WIDTH-1:0]   win_data,
  output logic [DIM_WIDTH-1:0]        win_row,
  output logic [DIM_WIDTH-1:0]        win_col
);

  localparam int TAPS = K * K;
  localparam int CW   = DIM_WIDTH + 3;
  localparam int TW   = $clog2(TAPS);
`ifdef WINDOW_FETCH_ZERO_PAD_EN
  localparam int PAD     = (K - 1) / 2;
  localparam int MIN_DIM = 1;
`else
  localparam int PAD     = 0;
  localparam int MIN_DIM = K;
`endif
  localparam logic signed [CW-1:0]  START_S   = CW'(-PAD);
  // A row/column is finished when the next origin would leave no room for K-PAD taps.
  localparam logic signed [CW-1:0]  LIMIT_S   = CW'(K - PAD);
  localparam logic [DIM_WIDTH-1:0]  MIN_DIM_D = DIM_WIDTH'(MIN_DIM);
  localparam logic [ADDR_WIDTH-1:0] PAD_A     = ADDR_WIDTH'(PAD);

  wf_state_e             r_state;
  wf_state_e             w_state_next;
  logic [DIM_WIDTH-1:0]  r_img_w, r_img_h, r_oy, r_ox;
  logic [1:0]            r_stride;
  logic [ADDR_WIDTH-1:0] r_row_addr, r_row_step;
  logic signed [CW-1:0]  r_py, r_px;
  logic                  r_cap_en, r_cap_ok;
  logic [TW-1:0]         r_cap_tap;
  logic [DATA_WIDTH-1:0] r_win [TAPS];

  logic [1:0]            w_stride_in;
  logic [ADDR_WIDTH-1:0] w_img_w_in, w_row_step_in;
  logic                  w_empty, w_accept, w_hs, w_col_end, w_row_end, w_last, w_load;
  logic signed [CW-1:0]  w_stride_s, w_img_w_s, w_img_h_s;
  logic signed [CW-1:0]  w_nx_py, w_nx_px, w_ld_py, w_ld_px;
  logic [ADDR_WIDTH-1:0] w_nx_row_addr, w_ld_row_addr, w_ld_addr;
  logic [DIM_WIDTH-1:0]  w_nx_oy, w_nx_ox;
  logic [ADDR_WIDTH-1:0] w_tap_addr;
  logic                  w_in_bounds, w_tap_last;
  logic [TW-1:0]         w_tap;

  assign w_stride_in   = (stride == 2'd0) ? 2'd1 : stride;
  assign w_img_w_in    = ADDR_WIDTH'(img_w);
  assign w_row_step_in = (w_stride_in[0] ? w_img_w_in : '0) +
                         (w_stride_in[1] ? {w_img_w_in[ADDR_WIDTH-2:0], 1'b0} : '0);
  assign w_empty  = (img_w < MIN_DIM_D) || (img_h < MIN_DIM_D);
  assign w_accept = (r_state == WF_IDLE) && start;
  assign w_hs     = (r_state == WF_HOLD) && win_ready;

  assign w_stride_s = CW'(r_stride);
  assign w_img_w_s  = CW'(r_img_w);
  assign w_img_h_s  = CW'(r_img_h);
  assign w_col_end  = (r_px + w_stride_s + LIMIT_S) > w_img_w_s;
  assign w_row_end  = (r_py + w_stride_s + LIMIT_S) > w_img_h_s;
  assign w_last     = w_col_end && w_row_end;

  always_comb begin
    w_nx_px       = r_px + w_stride_s;
    w_nx_py       = r_py;
    w_nx_row_addr = r_row_addr;
    w_nx_ox       = r_ox + DIM_WIDTH'(1);
    w_nx_oy       = r_oy;
    if (w_col_end) begin
      w_nx_px       = START_S;
      w_nx_py       = r_py + w_stride_s;
      w_nx_row_addr = r_row_addr + r_row_step;
      w_nx_ox       = '0;
      w_nx_oy       = r_oy + DIM_WIDTH'(1);
    end
  end

  // The generator is loaded from the live inputs on start, else from the next position.
  always_comb begin
    w_ld_row_addr = w_nx_row_addr;
    w_ld_py       = w_nx_py;
    w_ld_px       = w_nx_px;
    if (r_state == WF_IDLE) begin
      w_ld_row_addr = base_addr - PAD_A * w_img_w_in;
      w_ld_py       = START_S;
      w_ld_px       = START_S;
    end
  end

  assign w_ld_addr = w_ld_row_addr + ADDR_WIDTH'(w_ld_px);
  assign w_load    = (w_accept && !w_empty) || (w_hs && !w_last);

  window_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DIM_WIDTH (DIM_WIDTH),
    .K         (K),
    .CW        (CW),
    .TW        (TW)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_step     (r_state == WF_FETCH),
    .i_win_addr (w_ld_addr),
    .i_py       (w_ld_py),
    .i_px       (w_ld_px),
    .i_img_w    (r_img_w),
    .i_img_h    (r_img_h),
    .o_addr     (w_tap_addr),
    .o_in_bounds(w_in_bounds),
    .o_tap      (w_tap),
    .o_last     (w_tap_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= WF_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WF_IDLE:  if (start) w_state_next = w_empty ? WF_DONE : WF_FETCH;
      WF_FETCH: if (w_tap_last) w_state_next = WF_DRAIN;
      WF_DRAIN: w_state_next = WF_HOLD;
      WF_HOLD:  if (win_ready) w_state_next = w_last ? WF_DONE : WF_FETCH;
      WF_DONE:  w_state_next = WF_IDLE;
      default:  w_state_next = WF_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != WF_IDLE);
    done      = (r_state == WF_DONE);
    win_valid = (r_state == WF_HOLD);
    mem_en    = (r_state == WF_FETCH) && w_in_bounds;
    mem_addr  = mem_en ? w_tap_addr : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_img_w    <= '0;
      r_img_h    <= '0;
      r_stride   <= '0;
      r_row_step <= '0;
      r_row_addr <= '0;
      r_py       <= '0;
      r_px       <= '0;
      r_oy       <= '0;
      r_ox       <= '0;
    end else if (w_accept) begin
      r_img_w    <= img_w;
      r_img_h    <= img_h;
      r_stride   <= w_stride_in;
      r_row_step <= w_row_step_in;
      r_row_addr <= w_ld_row_addr;
      r_py       <= START_S;
      r_px       <= START_S;
      r_oy       <= '0;
      r_ox       <= '0;
    end else if (w_hs && !w_last) begin
      r_row_addr <= w_nx_row_addr;
      r_py       <= w_nx_py;
      r_px       <= w_nx_px;
      r_oy       <= w_nx_oy;
      r_ox       <= w_nx_ox;
    end
  end

  // Read data returns one cycle after the strobe, so tap bookkeeping is delayed to match.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_en  <= 1'b0;
      r_cap_ok  <= 1'b0;
      r_cap_tap <= '0;
    end else begin
      r_cap_en  <= (r_state == WF_FETCH);
      r_cap_ok  <= w_in_bounds;
      r_cap_tap <= w_tap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < TAPS; t++) r_win[t] <= '0;
    end else if (r_cap_en) begin
      r_win[r_cap_tap] <= r_cap_ok ? mem_rdata : '0;
    end
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      assign win_data[tap_lsb(gi, gj, K, DATA_WIDTH) +: DATA_WIDTH] = r_win[gi * K + gj];
    end
  end

  assign win_row = r_oy;
  assign win_col = r_ox;

endmodule

// File: tb/tb_window_fetch.sv
// Randomized self-checking bench for window_fetch against a direct
// per-window reference model of the map walk (memory holds 0x0400+i).
module tb_window_fetch;

  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int KK   = 5;
  localparam int DMW  = 8;
  localparam int TAPS = KK * KK;
  localparam int VW   = TAPS * DW;
`ifdef WINDOW_FETCH_ZERO_PAD_EN
  localparam int PAD = 2;
`else
  localparam int PAD = 0;
`endif

  logic           clk;
  logic           rst;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic [DMW-1:0] img_w;
  logic [DMW-1:0] img_h;
  logic [1:0]     stride;
  logic           busy;
  logic           done;
  logic           mem_en;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_rdata;
  logic           win_valid;
  logic           win_ready;
  logic [VW-1:0]  win_data;
  logic [DMW-1:0] win_row;
  logic [DMW-1:0] win_col;

  int checks = 0;
  int errors = 0;

  window_fetch #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .K         (KK),
    .DIM_WIDTH (DMW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .img_w    (img_w),
    .img_h    (img_h),
    .stride   (stride),
    .busy     (busy),
    .done     (done),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_data (win_data),
    .win_row  (win_row),
    .win_col  (win_col)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory preloaded with mem[i] = 0x0400 + i, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= DW'(16'h0400 + mem_addr);
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int out_dim(input int n, input int s);
    if (PAD > 0) return (n == 0) ? 0 : (n - 1) / s + 1;
    return (n < KK) ? 0 : (n - KK) / s + 1;
  endfunction

  function automatic bit tap_in_map(input int w, input int h, input int s,
                                    input int oy, input int ox, input int r, input int c);
    int y = oy * s + r - PAD;
    int x = ox * s + c - PAD;
    return (y >= 0) && (y < h) && (x >= 0) && (x < w);
  endfunction

  function automatic longint tap_value(input int w, input int h, input int s, input int base,
                                       input int oy, input int ox, input int r, input int c);
    int y = oy * s + r - PAD;
    int x = ox * s + c - PAD;
    if (!tap_in_map(w, h, s, oy, ox, r, c)) return 0;
    return longint'((32'h0400 + base + y * w + x) & 32'hFFFF);
  endfunction

  task automatic run_map(input int w, input int h, input int s, input int base, input int ready_pct);
    int s_eff = (s == 0) ? 1 : s;
    int ow = out_dim(w, s_eff);
    int oh = out_dim(h, s_eff);
    int nwin = ow * oh;
    int ow_div = (ow == 0) ? 1 : ow;
    int exp_reads = 0;
    int cyc = 0, widx = 0, reads = 0, last_hs = 0, done_cyc = -1;
    bit prev_valid = 1'b0, prev_hs = 1'b0;
    logic [VW-1:0] held = '0;

    for (int k = 0; k < nwin; k++)
      for (int r = 0; r < KK; r++)
        for (int c = 0; c < KK; c++)
          if (tap_in_map(w, h, s_eff, k / ow_div, k % ow_div, r, c)) exp_reads++;

    start = 1'b1; img_w = DMW'(w); img_h = DMW'(h); stride = 2'(s); base_addr = AW'(base);
    tick();
    cyc = 1;
    start = 1'b0;
    while (cyc < 8000) begin
      if (mem_en) reads++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (win_valid) begin
        check("no_read_in_hold", longint'(mem_en), 0);
        if (!prev_valid || prev_hs) begin
          check($sformatf("w%0d_valid_cycle", widx), cyc, last_hs + 27);
          check($sformatf("w%0d_row", widx), longint'(win_row), widx / ow_div);
          check($sformatf("w%0d_col", widx), longint'(win_col), widx % ow_div);
          for (int r = 0; r < KK; r++)
            for (int c = 0; c < KK; c++)
              check($sformatf("w%0d_tap%0d", widx, r * KK + c),
                    longint'(win_data[(r * KK + c) * DW +: DW]),
                    tap_value(w, h, s_eff, base, widx / ow_div, widx % ow_div, r, c));
          held = win_data;
        end else begin
          check($sformatf("w%0d_stable", widx), longint'(win_data == held), 1);
        end
        win_ready = ($urandom_range(99) < ready_pct);
        prev_hs = win_ready;
        if (win_ready) begin
          last_hs = cyc;
          widx++;
        end
        start = ($urandom_range(3) == 0);
      end else begin
        win_ready = $urandom_range(1) == 1;
        prev_hs = 1'b0;
        start = 1'b0;
      end
      img_w = DMW'($urandom); img_h = DMW'($urandom);
      stride = 2'($urandom); base_addr = AW'($urandom);
      prev_valid = win_valid;
      tick();
      cyc++;
    end
    start = 1'b0;
    win_ready = 1'b0;
    check("done_seen", longint'(done_cyc >= 0), 1);
    check("done_cycle", done_cyc, last_hs + 1);
    check("win_count", widx, nwin);
    check("read_count", reads, exp_reads);
    tick();
    check("idle_after_done", longint'({busy, done}), 0);
    $display("map w=%0d h=%0d s=%0d base=0x%0h: %0d windows, %0d reads, done at cycle %0d",
             w, h, s, base, widx, reads, done_cyc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; img_w = '0; img_h = '0;
    stride = '0; win_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_mem_en", longint'(mem_en), 0);
    check("rst_win_valid", longint'(win_valid), 0);
    check("rst_mem_addr", longint'(mem_addr), 0);
    check("rst_win_data_nonzero", longint'(win_data != '0), 0);
    check("rst_win_pos", longint'({win_row, win_col}), 0);
    rst = 1'b0;
    tick();

    run_map(5, 5, 1, 0, 100);
    run_map(7, 6, 1, 0, 100);
    run_map(9, 5, 2, 16'h0010, 100);
    run_map(7, 6, 1, 0, 25);
    run_map(4, 6, 1, 0, 100);
    run_map(6, 7, 0, 16'hFFF0, 60);

    // Reset in the middle of a fetch.
    start = 1'b1; img_w = 8'd5; img_h = 8'd5; stride = 2'd1; base_addr = '0;
    tick();
    start = 1'b0;
    repeat (11) tick();
    check("midfetch_busy_before_rst", longint'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_mem_en", longint'(mem_en), 0);
    check("midrst_mem_addr", longint'(mem_addr), 0);
    check("midrst_win_valid", longint'(win_valid), 0);
    check("midrst_done", longint'(done), 0);
    check("midrst_win_data_nonzero", longint'(win_data != '0), 0);
    check("midrst_win_pos", longint'({win_row, win_col}), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_quiet", longint'({mem_en, win_valid, busy}), 0);
    end
    run_map(5, 5, 1, 0, 100);

    for (int i = 0; i < 10; i++)
      run_map($urandom_range(9, (PAD > 0) ? 1 : 3), $urandom_range(9, (PAD > 0) ? 1 : 3),
              $urandom_range(3), $urandom_range(16'hFFFF), $urandom_range(90, 30));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
